// File: rtl/flash_stream_pkg.sv
// Shared constants and FSM encodings for the flash block streamer.
// Imported by the streamer top and its ping-pong buffer RAM.
package flash_stream_pkg;

    localparam int FLASH_ADDR_W       = 24;
    localparam int BYTE_W             = 8;
    localparam int DEFAULT_BLOCK_SIZE = 512;

    localparam logic [BYTE_W-1:0] FLASH_READ_CMD = 8'h03;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT
    } fill_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_FETCH,
        D_OUT
    } drain_state_e;

endpackage

// File: rtl/flash_block_bram.sv
// Simple dual-port byte RAM holding both ping-pong banks.
// One write port, one registered read port; contents are not reset.
module flash_block_bram
    import flash_stream_pkg::*;
#(
    parameter int DEPTH = 2 * DEFAULT_BLOCK_SIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/flash_block_streamer.sv
// Streams N flash blocks through a two-bank ping-pong buffer.
// Fill of one bank overlaps the valid/ready drain of the other.
module flash_block_streamer
    import flash_stream_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int MAX_BLOCKS = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start_stb,
    input  logic [FLASH_ADDR_W-1:0] i_start_addr,
    input  logic [MAX_BLOCKS-1:0]   i_num_blocks,
    output logic                    o_busy,
    output logic                    o_done_stb,
    output logic [FLASH_ADDR_W-1:0] o_flash_read_addr,
    output logic                    o_flash_read_stb,
    input  logic                    i_flash_read_done_stb,
    input  logic                    i_bram_wr_stb,
    input  logic [9:0]              i_bram_wr_addr,
    input  logic [BYTE_W-1:0]       i_bram_wr_data,
    output logic                    o_stream_valid,
    output logic [BYTE_W-1:0]       o_stream_data,
    output logic                    o_stream_last,
    input  logic                    i_stream_ready
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [FLASH_ADDR_W-1:0] ADDR_STEP = FLASH_ADDR_W'(BLOCK_SIZE);
    localparam logic [MAX_BLOCKS-1:0] CNT_ONE = MAX_BLOCKS'(1);
    localparam logic [10:0] WR_LIMIT = 11'(BLOCK_SIZE);

    fill_state_e fill_q, fill_d;
    drain_state_e drain_q, drain_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic stb_q, stb_d;
    logic fill_sel_q, fill_sel_d;
    logic drain_sel_q, drain_sel_d;
    logic [1:0] full_q, full_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [MAX_BLOCKS-1:0] count_q, count_d;
    logic [MAX_BLOCKS-1:0] req_q, req_d;
    logic [MAX_BLOCKS-1:0] drained_q, drained_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic start_ok;
    logic fin;
    logic [1:0] fill_set;
    logic [1:0] drain_clr;
    logic [MAX_BLOCKS-1:0] req_nxt;
    logic [MAX_BLOCKS-1:0] drained_nxt;
    logic wr_en;
    logic [IDX_W:0] wr_addr;
    logic rd_en;
    logic [IDX_W:0] rd_addr;
    logic [BYTE_W-1:0] rd_data;
    logic valid;

    assign start_ok    = i_start_stb && !busy_q;
    assign req_nxt     = req_q + CNT_ONE;
    assign drained_nxt = drained_q + CNT_ONE;

    // Writes land only in the bank currently being filled.
    assign wr_en = (fill_q == F_WAIT) && i_bram_wr_stb
                   && ({1'b0, i_bram_wr_addr} < WR_LIMIT);
    assign wr_addr = {fill_sel_q, i_bram_wr_addr[IDX_W-1:0]};

    always_comb begin
        fill_d     = fill_q;
        addr_d     = addr_q;
        count_d    = count_q;
        req_d      = req_q;
        fill_sel_d = fill_sel_q;
        stb_d      = 1'b0;
        fill_set   = 2'b00;
        unique case (fill_q)
            F_IDLE: begin
                if (start_ok && (i_num_blocks != '0)) begin
                    addr_d  = i_start_addr;
                    count_d = i_num_blocks;
                    req_d   = '0;
                    fill_d  = F_REQ;
                end
            end
            F_REQ: begin
                if (!full_q[fill_sel_q]) begin
                    stb_d  = 1'b1;
                    fill_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (i_flash_read_done_stb) begin
                    fill_set[fill_sel_q] = 1'b1;
                    fill_sel_d = ~fill_sel_q;
                    addr_d     = addr_q + ADDR_STEP;
                    req_d      = req_nxt;
                    // Issue straight away when the other bank is free.
                    if (req_nxt < count_q) begin
                        if (!full_q[~fill_sel_q]) begin
                            stb_d = 1'b1;
                        end else begin
                            fill_d = F_REQ;
                        end
                    end else begin
                        fill_d = F_IDLE;
                    end
                end
            end
            default: fill_d = F_IDLE;
        endcase
    end

    always_comb begin
        drain_d     = drain_q;
        idx_d       = idx_q;
        drain_sel_d = drain_sel_q;
        drained_d   = drained_q;
        drain_clr   = 2'b00;
        rd_en       = 1'b0;
        rd_addr     = {drain_sel_q, idx_q};
        fin         = 1'b0;
        unique case (drain_q)
            D_IDLE: begin
                if (full_q[drain_sel_q]) begin
                    drain_d = D_FETCH;
                end
            end
            D_FETCH: begin
                rd_en   = 1'b1;
                drain_d = D_OUT;
            end
            D_OUT: begin
                if (i_stream_ready) begin
                    if (idx_q == IDX_LAST) begin
                        drain_clr[drain_sel_q] = 1'b1;
                        drain_sel_d = ~drain_sel_q;
                        idx_d       = '0;
                        drain_d     = D_IDLE;
                        drained_d   = drained_nxt;
                        if (drained_nxt == count_q) begin
                            fin       = 1'b1;
                            drained_d = '0;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        rd_en   = 1'b1;
                        rd_addr = {drain_sel_q, idx_q + IDX_ONE};
                    end
                end
            end
            default: drain_d = D_IDLE;
        endcase
    end

    always_comb begin
        full_d = (full_q | fill_set) & ~drain_clr;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_ok) begin
            if (i_num_blocks != '0) begin
                busy_d = 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
        if (fin) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_q      <= F_IDLE;
            drain_q     <= D_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stb_q       <= 1'b0;
            fill_sel_q  <= 1'b0;
            drain_sel_q <= 1'b0;
            full_q      <= 2'b00;
            addr_q      <= '0;
            count_q     <= '0;
            req_q       <= '0;
            drained_q   <= '0;
            idx_q       <= '0;
        end else begin
            fill_q      <= fill_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stb_q       <= stb_d;
            fill_sel_q  <= fill_sel_d;
            drain_sel_q <= drain_sel_d;
            full_q      <= full_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            req_q       <= req_d;
            drained_q   <= drained_d;
            idx_q       <= idx_d;
        end
    end

    flash_block_bram #(
        .DEPTH (2 * BLOCK_SIZE)
    ) u_bram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (i_bram_wr_data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign valid             = (drain_q == D_OUT);
    assign o_stream_valid    = valid;
    assign o_stream_data     = valid ? rd_data : '0;
    assign o_stream_last     = valid && (idx_q == IDX_LAST);
    assign o_busy            = busy_q;
    assign o_done_stb        = done_q;
    assign o_flash_read_stb  = stb_q;
    assign o_flash_read_addr = stb_q ? addr_q : '0;

endmodule

// File: tb/tb_flash_block_streamer.sv
// Directed bench for flash_block_streamer with a flash/BRAM-writer model
// and a byte/request scoreboard.
module tb_flash_block_streamer;

    localparam int BS = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stb = 1'b0;
    logic [23:0] start_addr = '0;
    logic [15:0] num_blocks = '0;
    logic        busy, done_stb, rd_stb;
    logic [23:0] rd_addr;
    logic        fm_done = 1'b0;
    logic        fm_wr = 1'b0;
    logic [9:0]  fm_addr = '0;
    logic [7:0]  fm_data = '0;
    logic        st_wr = 1'b0;
    logic [9:0]  st_addr = '0;
    logic [7:0]  st_data = '0;
    logic        s_valid, s_last;
    logic [7:0]  s_data;
    logic        ready = 1'b1;

    int vec = 0;
    int miscmp = 0;
    int cyc = 0;
    int gen = 0;
    int fm_k = 0;
    bit fm_busy = 1'b0;
    bit fm_stray = 1'b0;
    bit bp_mode = 1'b0;
    bit done_seen = 1'b0;
    bit chk_first = 1'b0;
    int first_req_cyc = 0;
    int exp_done_cyc = -1;
    int bytes_left = 0;
    int accepted = 0;
    int reqs = 0;
    int drained = 0;

    logic [8:0]  exp_q[$];
    logic [23:0] req_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flash_block_streamer #(
        .BLOCK_SIZE (BS),
        .MAX_BLOCKS (16)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_start_stb           (start_stb),
        .i_start_addr          (start_addr),
        .i_num_blocks          (num_blocks),
        .o_busy                (busy),
        .o_done_stb            (done_stb),
        .o_flash_read_addr     (rd_addr),
        .o_flash_read_stb      (rd_stb),
        .i_flash_read_done_stb (fm_done),
        .i_bram_wr_stb         (fm_wr | st_wr),
        .i_bram_wr_addr        (st_wr ? st_addr : fm_addr),
        .i_bram_wr_data        (st_wr ? st_data : fm_data),
        .o_stream_valid        (s_valid),
        .o_stream_data         (s_data),
        .o_stream_last         (s_last),
        .i_stream_ready        (ready)
    );

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
        end
    end

    // Flash model: answers each read strobe with BS writes then a done pulse.
    initial begin
        int g;
        int k;
        forever begin
            @(negedge clk);
            if (rst_n && rd_stb) begin
                g = gen;
                k = fm_k;
                fm_k++;
                fm_busy = 1'b1;
                repeat (3) @(posedge clk);
                for (int i = 0; i < BS; i++) begin
                    @(posedge clk);
                    #1;
                    fm_wr   = 1'b1;
                    fm_addr = 10'(i);
                    fm_data = 8'(i + 3 * k);
                    if (g == gen) exp_q.push_back({(i == BS - 1), fm_data});
                    if (fm_stray && i == 100) begin
                        @(posedge clk);
                        #1;
                        fm_addr = 10'd600;
                        fm_data = 8'hEE;
                    end
                end
                @(posedge clk);
                #1;
                fm_wr   = 1'b0;
                fm_done = 1'b1;
                @(posedge clk);
                #1;
                fm_done = 1'b0;
                fm_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0]  e;
        logic [23:0] ea;
        if (rst_n) begin
            if (s_valid) begin
                vec++;
                assert (exp_q.size() != 0) else begin
                    miscmp++;
                    $error("FAIL stream_extra got %h want none", s_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    vec++;
                    assert ({s_last, s_data} === e) else begin
                        miscmp++;
                        $error("FAIL stream_byte got %h want %h", {s_last, s_data}, e);
                    end
                    if (ready) begin
                        void'(exp_q.pop_front());
                        accepted++;
                        if (e[8]) drained++;
                        bytes_left--;
                        if (bytes_left == 0) exp_done_cyc = cyc + 1;
                    end
                end
            end
            if (rd_stb) begin
                reqs++;
                vec++;
                assert (req_q.size() != 0) else begin
                    miscmp++;
                    $error("FAIL req_extra got %h want none", rd_addr);
                end
                if (req_q.size() != 0) begin
                    ea = req_q.pop_front();
                    vec++;
                    assert (rd_addr === ea) else begin
                        miscmp++;
                        $error("FAIL req_addr got %h want %h", rd_addr, ea);
                    end
                end
                if (chk_first) begin
                    chk_first = 1'b0;
                    vec++;
                    assert (cyc === first_req_cyc) else begin
                        miscmp++;
                        $error("FAIL first_req_cyc got %0d want %0d", cyc, first_req_cyc);
                    end
                end
                vec++;
                assert ((reqs - drained) <= 2) else begin
                    miscmp++;
                    $error("FAIL req_ahead got %0d want <=2", reqs - drained);
                end
            end
            if (done_stb) begin
                done_seen = 1'b1;
                vec++;
                assert ({busy, cyc} === {1'b0, exp_done_cyc}) else begin
                    miscmp++;
                    $error("FAIL done_timing got busy=%0b cyc=%0d want busy=0 cyc=%0d",
                           busy, cyc, exp_done_cyc);
                end
            end
        end
    end

    task automatic start_cmd(input logic [23:0] a, input int n);
        logic [23:0] x;
        x = a;
        for (int j = 0; j < n; j++) begin
            req_q.push_back(x);
            x = x + 24'd512;
        end
        fm_k = 0;
        reqs = 0;
        drained = 0;
        accepted = 0;
        bytes_left = n * BS;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        start_stb  = 1'b1;
        start_addr = a;
        num_blocks = 16'(n);
        exp_done_cyc = (n == 0) ? cyc + 1 : -1;
        first_req_cyc = cyc + 2;
        chk_first = (n != 0);
        @(posedge clk);
        #1;
        start_stb = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done_seen && t < 30000) begin
            @(posedge clk);
            t++;
        end
        vec++;
        assert (done_seen === 1'b1) else begin
            miscmp++;
            $error("FAIL %s_done got %0b want 1", tag, done_seen);
        end
        @(negedge clk);
        vec++;
        assert ({busy, 8'(exp_q.size()), 8'(req_q.size())} === 17'd0) else begin
            miscmp++;
            $error("FAIL %s_drain got busy=%0b bytes=%0d reqs=%0d want 0/0/0",
                   tag, busy, exp_q.size(), req_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        vec++;
        assert ({busy, done_stb, rd_stb, rd_addr, s_valid, s_data, s_last} === 37'd0) else begin
            miscmp++;
            $error("FAIL %s got %h want 0", tag,
                   {busy, done_stb, rd_stb, rd_addr, s_valid, s_data, s_last});
        end
    endtask

    initial begin
        int t;
        #2;
        check_zero("reset_outputs");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle_outputs");

        @(posedge clk);
        #1;
        st_wr   = 1'b1;
        st_addr = 10'd5;
        st_data = 8'hEE;
        @(posedge clk);
        #1;
        st_wr = 1'b0;

        start_cmd(24'h001000, 1);
        wait_done("single");

        start_cmd(24'hFFFE00, 3);
        wait_done("three_wrap");

        bp_mode = 1'b1;
        start_cmd(24'h020000, 4);
        wait_done("backpressure");
        bp_mode = 1'b0;

        start_cmd(24'h030000, 0);
        wait_done("zero_count");
        repeat (5) @(posedge clk);

        start_cmd(24'h100000, 2);
        repeat (50) @(posedge clk);
        #1;
        start_stb  = 1'b1;
        start_addr = 24'h300000;
        num_blocks = 16'd5;
        @(posedge clk);
        #1;
        start_stb = 1'b0;
        wait_done("busy_start");

        fm_stray = 1'b1;
        start_cmd(24'h200000, 1);
        wait_done("stray_mid");
        fm_stray = 1'b0;

        start_cmd(24'h040000, 2);
        t = 0;
        while (accepted < BS + 200 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        vec++;
        assert (accepted === BS + 200) else begin
            miscmp++;
            $error("FAIL rst_reach got %0d want %0d", accepted, BS + 200);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        gen++;
        exp_q.delete();
        req_q.delete();
        bytes_left = 0;
        chk_first = 1'b0;
        #1;
        check_zero("mid_reset");
        t = 0;
        while (fm_busy && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_cmd(24'h050000, 1);
        wait_done("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
